// File: rtl/apb_master_q.sv
// apb_master_q: queued APB master.
//
// Host commands are buffered in a FIFO and issued one at a time as APB
// SETUP/ACCESS transfers. The target slave is decoded from the top
// SEL_BITS address bits. Every command produces exactly one response,
// in command order.
//
// Ports
//   P_clk, P_reset          clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_rw/addr/wdata       command payload (rw: 1 = write)
//   rsp_valid               one-cycle response strobe (no backpressure)
//   rsp_rdata/err/timeout   response payload
//   P_sel..P_wdata          registered APB request outputs
//   P_rdata/ready/slverr    APB slave response inputs
//   P_busy                  work queued, in flight, or a response is being delivered
//   dbg_state               current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Handshake: a command is transferred on every rising edge where
// cmd_valid && cmd_ready are both high. cmd_ready depends only on the FIFO
// occupancy (never on cmd_valid), so the host may hold cmd_valid and its
// payload steady until it sees cmd_ready. The response side has no ready:
// rsp_valid is a single-cycle strobe the host must capture.

module apb_master_q #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  P_clk,
  input  logic                  P_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [NUM_SLAVES-1:0] P_sel,
  output logic                  P_enable,
  output logic                  P_write,
  output logic [ADDR_WIDTH-1:0] P_addr,
  output logic [DATA_WIDTH-1:0] P_wdata,
  input  logic [DATA_WIDTH-1:0] P_rdata,
  input  logic                  P_ready,
  input  logic                  P_slverr,
  output logic                  P_busy,
  output logic [1:0]            dbg_state
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
  localparam int SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Value of the wait counter during the last ACCESS cycle allowed to stall.
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic                  fifo_rw    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  ready_en;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign fifo_empty = (count == '0);
  // ready_en holds cmd_ready low for the first cycle after reset.
  assign cmd_ready  = ready_en && (count != FIFO_FULL_CNT);
  assign push       = cmd_valid && cmd_ready;

  always_ff @(posedge P_clk) begin
    if (push) begin
      fifo_rw[wr_ptr]    <= cmd_rw;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Head-of-queue decode
  // ---------------------------------------------------------------------
  logic                  head_rw;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [SEL_W-1:0]      head_idx;
  logic                  head_ok;
  logic [NUM_SLAVES-1:0] head_sel;

  assign head_rw    = fifo_rw[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];

  generate
    if (SEL_BITS == 0) begin : g_one_slave
      assign head_idx = '0;
    end else begin : g_multi_slave
      assign head_idx = head_addr[ADDR_WIDTH-1 -: SEL_BITS];
    end
  endgenerate

  // Non-power-of-two slave counts leave some index values unmapped.
  assign head_ok  = (32'(head_idx) < NUM_SLAVES);
  assign head_sel = NUM_SLAVES'(1) << head_idx;

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             load;       // pop head into the APB request registers
  logic             dec_err;    // pop head that maps to no slave
  logic             complete;   // ACCESS finished with P_ready
  logic             abort;      // ACCESS timed out
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    dec_err    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ok) begin
            load       = 1'b1;
            state_next = ST_SETUP;
          end else begin
            dec_err = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (P_ready) begin
          complete = 1'b1;
          // A decode-error head is left for IDLE so its response cannot
          // collide with the completion response on the next cycle.
          if (!fifo_empty && head_ok) begin
            pop        = 1'b1;
            load       = 1'b1;
            state_next = ST_SETUP;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      P_sel       <= '0;
      P_enable    <= 1'b0;
      P_write     <= 1'b0;
      P_addr      <= '0;
      P_wdata     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      P_enable <= (state_next == ST_ACCESS);

      // The APB request registers double as the holding registers.
      if (load) begin
        P_sel   <= head_sel;
        P_addr  <= head_addr;
        P_write <= head_rw;
        P_wdata <= head_rw ? head_wdata : '0;
      end else if (complete || abort) begin
        P_sel <= '0;
      end

      if (load) begin
        wait_cnt <= '0;
      end else if ((state == ST_ACCESS) && !P_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // P_write still describes the finishing transfer here; a same-cycle
      // load only updates it at this edge.
      rsp_valid   <= complete || abort || dec_err;
      rsp_err     <= abort || dec_err || (complete && P_slverr);
      rsp_timeout <= abort;
      rsp_rdata   <= (complete && !P_write && !P_slverr) ? P_rdata : '0;
    end
  end

  assign P_busy    = !fifo_empty || (state != ST_IDLE) || rsp_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_apb_master_q.sv
// Testbench for apb_master_q: table of single-command transfers against a
// memory-backed slave model, plus hand-written sequences for decode errors
// (3-slave instance), FIFO full / back-to-back streaming and mid-transfer reset.

module tb_apb_master_q;

  // ---------------- clock / reset ----------------
  logic P_clk = 1'b0;
  logic P_reset;
  always #5 P_clk = ~P_clk;

  // ---------------- main DUT (2 slaves) ----------------
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [1:0] P_sel;
  logic       P_enable, P_write;
  logic [7:0] P_addr, P_wdata, P_rdata;
  logic       P_ready, P_slverr, P_busy;
  logic [1:0] dbg_state;

  apb_master_q #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(2),
                 .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .P_clk(P_clk), .P_reset(P_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write), .P_addr(P_addr),
    .P_wdata(P_wdata), .P_rdata(P_rdata), .P_ready(P_ready),
    .P_slverr(P_slverr), .P_busy(P_busy), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (3 slaves) ----------------
  logic       c3_valid, c3_ready;
  logic [7:0] c3_addr;
  logic       c3_rsp_valid, c3_rsp_err, c3_rsp_to;
  logic [7:0] c3_rsp_rdata;
  logic [2:0] c3_sel;
  logic       c3_enable, c3_write;
  logic [7:0] c3_paddr, c3_pwdata;
  logic       c3_busy;
  logic [1:0] c3_state;

  apb_master_q #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(3),
                 .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut3 (
    .P_clk(P_clk), .P_reset(P_reset),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_rw(1'b0),
    .cmd_addr(c3_addr), .cmd_wdata(8'h00),
    .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rsp_rdata), .rsp_err(c3_rsp_err),
    .rsp_timeout(c3_rsp_to),
    .P_sel(c3_sel), .P_enable(c3_enable), .P_write(c3_write), .P_addr(c3_paddr),
    .P_wdata(c3_pwdata), .P_rdata(8'h11), .P_ready(1'b1),
    .P_slverr(1'b0), .P_busy(c3_busy), .dbg_state(c3_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge P_clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       slverr;
    int         wait_n;     // ACCESS cycles with P_ready low (255 = never ready)
    logic [1:0] exp_sel;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_acc;    // ACCESS cycles seen
    int         exp_lat;    // cycles from command accept to rsp_valid
  } vec_t;

  vec_t vecs [10];

  // One command through an otherwise idle DUT; entered and left at a negedge.
  task automatic run_vec(input int i);
    vec_t v;
    int   cyc, acc, setups;
    bit   got;
    v = vecs[i];
    check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
    tick();
    cmd_valid = 1'b0;
    check($sformatf("v%0d_pop_cycle_bus", i), {30'd0, |P_sel, P_enable}, 32'd0);
    cyc = 1; acc = 0; setups = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      if (rsp_valid) begin
        got = 1'b1;
        check($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_err_to", i), {30'd0, rsp_err, rsp_timeout},
              {30'd0, v.exp_err, v.exp_to});
        check($sformatf("v%0d_latency", i), 32'(cyc), 32'(v.exp_lat));
        check($sformatf("v%0d_access_cycles", i), 32'(acc), 32'(v.exp_acc));
        check($sformatf("v%0d_setups", i), 32'(setups), (v.exp_acc > 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_bus_idle_at_rsp", i), {29'd0, P_sel, P_enable}, 32'd0);
      end else begin
        if (P_enable) begin
          acc++;
          check($sformatf("v%0d_access_addr_sel", i), {22'd0, P_sel, P_addr},
                {22'd0, v.exp_sel, v.addr});
          P_ready = (acc == v.wait_n + 1);
          if (P_ready && P_write && !v.slverr) mem[P_addr] = P_wdata;
        end else begin
          P_ready = 1'b0;
          if (P_sel != 2'b00) begin
            setups++;
            check($sformatf("v%0d_setup", i), {13'd0, P_busy, P_write, P_sel, P_addr, P_wdata},
                  {13'd0, 1'b1, v.rw, v.exp_sel, v.addr, v.rw ? v.wdata : 8'h00});
          end
        end
        P_rdata  = mem[P_addr];
        P_slverr = v.slverr;
      end
      tick();
      cyc++;
    end
    if (!got) check($sformatf("v%0d_rsp_seen", i), 32'd0, 32'd1);
    // A stray P_ready while idle must not create a response.
    P_ready = 1'b1;
    tick();
    check($sformatf("v%0d_after", i), {28'd0, rsp_valid, P_busy, dbg_state}, 32'd0);
    P_ready = 1'b0; P_slverr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] fifo_addrs [6];
  logic [7:0] exp_v;

  initial begin
    P_reset = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    P_rdata = 8'h00; P_ready = 1'b0; P_slverr = 1'b0;
    c3_valid = 1'b0; c3_addr = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = ~8'(a);
    mem[8'h33] = 8'h3C;

    vecs[0] = '{1'b1, 8'h05, 8'hA5, 1'b0, 0,   2'b01, 8'h00, 1'b0, 1'b0, 1,  4};
    vecs[1] = '{1'b0, 8'h05, 8'h00, 1'b0, 0,   2'b01, 8'hA5, 1'b0, 1'b0, 1,  4};
    vecs[2] = '{1'b1, 8'h85, 8'h5A, 1'b0, 0,   2'b10, 8'h00, 1'b0, 1'b0, 1,  4};
    vecs[3] = '{1'b0, 8'h85, 8'h00, 1'b0, 3,   2'b10, 8'h5A, 1'b0, 1'b0, 4,  7};
    vecs[4] = '{1'b0, 8'h33, 8'h00, 1'b1, 0,   2'b01, 8'h00, 1'b1, 1'b0, 1,  4};
    vecs[5] = '{1'b1, 8'h40, 8'h77, 1'b1, 0,   2'b01, 8'h00, 1'b1, 1'b0, 1,  4};
    vecs[6] = '{1'b0, 8'h40, 8'h00, 1'b0, 0,   2'b01, 8'hBF, 1'b0, 1'b0, 1,  4};
    vecs[7] = '{1'b0, 8'hC1, 8'h00, 1'b0, 255, 2'b10, 8'h00, 1'b1, 1'b1, 16, 19};
    vecs[8] = '{1'b1, 8'hF0, 8'h99, 1'b0, 15,  2'b10, 8'h00, 1'b0, 1'b0, 16, 19};
    vecs[9] = '{1'b0, 8'hF0, 8'h00, 1'b0, 0,   2'b10, 8'h99, 1'b0, 1'b0, 1,  4};

    fifo_addrs = '{8'h10, 8'h91, 8'h12, 8'h93, 8'h14, 8'h95};

    // Reset state
    tick(); tick();
    P_reset = 1'b0;
    check("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, P_sel, P_enable,
                            P_write, P_addr, P_wdata, P_busy}, 32'd0);
    check("reset_cmd_ready_low", {30'd0, cmd_ready, c3_ready}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    tick();
    check("cmd_ready_after_reset", {30'd0, cmd_ready, c3_ready}, 32'd3);

    // Table-driven single transfers
    for (int i = 0; i < 10; i++) run_vec(i);

    // Decode error on the 3-slave instance: no bus activity, error response.
    check("d3_ready", 32'(c3_ready), 32'd1);
    c3_valid = 1'b1; c3_addr = 8'hC0;
    tick();
    c3_valid = 1'b0;
    check("d3_pop_sel", {28'd0, c3_sel, c3_enable}, 32'd0);
    tick();
    check("d3_dec_rsp", {20'd0, c3_rsp_valid, c3_rsp_err, c3_rsp_to, c3_rsp_rdata, 1'b0},
          {20'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    check("d3_dec_sel", {28'd0, c3_sel, c3_enable}, 32'd0);
    tick();
    check("d3_dec_after", {30'd0, c3_rsp_valid, c3_busy}, 32'd0);
    // Highest mapped slave on the 3-slave instance.
    c3_valid = 1'b1; c3_addr = 8'h80;
    tick();
    c3_valid = 1'b0;
    tick();
    check("d3_s2_setup", {28'd0, c3_sel, c3_enable}, {28'd0, 3'b100, 1'b0});
    tick();
    check("d3_s2_access", {28'd0, c3_sel, c3_enable}, {28'd0, 3'b100, 1'b1});
    tick();
    check("d3_s2_rsp", {22'd0, c3_rsp_valid, c3_rsp_err, c3_rsp_rdata},
          {22'd0, 1'b1, 1'b0, 8'h11});
    tick();

    // FIFO full with stalled slave, then back-to-back streaming.
    begin
      int k, n_rsp;
      k = 0; n_rsp = 0;
      for (int cyc = 0; cyc <= 21; cyc++) begin
        if (rsp_valid) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("b2b_unexpected_rsp", 32'd1, 32'd0);
          end else begin
            exp_v = exp_q.pop_front();
            check($sformatf("b2b_rsp%0d", n_rsp), {23'd0, rsp_err, rsp_rdata}, {24'd0, exp_v});
          end
        end
        if (cyc <= 9) check($sformatf("b2b_ready_c%0d", cyc), 32'(cmd_ready),
                            (cyc < 5 || cyc == 9) ? 32'd1 : 32'd0);
        if (cyc >= 3 && cyc <= 7)
          check($sformatf("b2b_stall_c%0d", cyc), {23'd0, P_enable, P_addr}, {23'd0, 1'b1, 8'h10});
        if (cyc >= 8 && cyc <= 18)
          check($sformatf("b2b_phase_c%0d", cyc), {29'd0, P_enable, P_sel},
                {29'd0, ((cyc - 8) % 2) == 0, fifo_addrs[(cyc - 7) / 2][7] ? 2'b10 : 2'b01});
        if (cyc == 19) check("b2b_idle_end", {29'd0, P_enable, P_sel}, 32'd0);
        if (k < 6) begin
          cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = fifo_addrs[k]; cmd_wdata = 8'h00;
          if (cmd_ready) begin
            exp_q.push_back(mem[fifo_addrs[k]]);
            k++;
          end
        end else begin
          cmd_valid = 1'b0;
        end
        P_ready  = (cyc >= 8);
        P_rdata  = mem[P_addr];
        P_slverr = 1'b0;
        tick();
      end
      P_ready = 1'b0;
      check("b2b_rsp_count", 32'(n_rsp), 32'd6);
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Reset in the middle of a stalled ACCESS with a second command queued.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h20;
    tick();
    cmd_addr = 8'h21;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("rst_mid_stalled", {30'd0, P_enable, P_busy}, 32'd3);
    P_reset = 1'b1;
    tick();
    P_reset = 1'b0;
    check("rst_mid_outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, P_sel, P_enable,
                              P_write, P_addr, P_wdata, P_busy}, 32'd0);
    check("rst_mid_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    check("rst_mid_ready_back", {30'd0, cmd_ready, P_busy}, 32'd2);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rst_fifo_discard_c%0d", c), {28'd0, rsp_valid, P_sel, P_busy}, 32'd0);
    end

    // Normal operation after reset.
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_q.md
Name: apb_master_q

Overview:
Parametrised next-generation APB master. It buffers host read/write commands in a FIFO and issues them as APB SETUP/ACCESS transfers to one of NUM_SLAVES slaves, decoded from the upper address bits. Each command returns exactly one response, with read data, PSLVERR status and an access-phase timeout. It sits between the host logic and the APB slave/memory fabric.

Parameters:
ADDR_WIDTH, 8, address width in bits; the slave index is the top SEL_BITS = clog2(NUM_SLAVES) bits.
DATA_WIDTH, 8, read and write data width.
NUM_SLAVES, 2, number of P_sel lines (at least 1; SEL_BITS = 0 when 1).
FIFO_DEPTH, 4, command FIFO entries (power of 2, at least 2).
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with P_ready low before abort; 0 disables the timeout.

Ports:
P_clk  in  1  clock; all logic on the rising edge.
P_reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_rw  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  target address.
cmd_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
rsp_err  out  1  PSLVERR, decode error or timeout.
rsp_timeout  out  1  the error was a timeout.
P_sel  out  NUM_SLAVES  one-hot slave select.
P_enable  out  1  APB enable.
P_write  out  1  APB direction.
P_addr  out  ADDR_WIDTH  APB address (full cmd_addr).
P_wdata  out  DATA_WIDTH  APB write data.
P_rdata  in  DATA_WIDTH  slave read data.
P_ready  in  1  slave ready.
P_slverr  in  1  slave error, sampled with P_ready.
P_busy  out  1  FIFO non-empty or a transfer in flight.

Behaviour:
- Reset: all outputs 0 except cmd_ready, which is 1 from the cycle after reset. FIFO empty, FSM in IDLE, wait counter 0. Reset during a transfer aborts it and produces no response.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full. It stays low when full even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - An entry pushed in cycle N is visible (non-empty) in cycle N+1.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE, FIFO non-empty: pop the head into holding registers.
  - Valid slave index: next cycle is SETUP.
  - Index >= NUM_SLAVES: no bus activity. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0. Stay in IDLE.
- SETUP (exactly 1 cycle):
  - P_sel[idx]=1, all other P_sel bits 0, P_enable=0.
  - P_addr, P_write and P_wdata are driven from the holding registers (P_wdata=0 on reads).
  - Next state is ACCESS.
- ACCESS: P_enable=1. P_sel, P_addr, P_write and P_wdata are held stable.
  - P_ready=1: the transfer completes. Next cycle rsp_valid=1 and rsp_err=P_slverr. rsp_rdata=P_rdata for a read with P_slverr=0, otherwise 0.
  - After completion with the FIFO non-empty: pop and go directly to SETUP. The next command's P_sel is driven and P_enable=0 (back-to-back transfers, no IDLE cycle).
  - After completion with the FIFO empty: go to IDLE, with P_sel=0 and P_enable=0.
  - P_ready=0: increment the wait counter.
  - Counter reaches TIMEOUT_CYCLES (non-zero): abort. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. P_sel and P_enable drop to 0 and the FSM returns to IDLE. A late P_ready is ignored.
  - The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), and it saturates.
- Latency:
  - Zero-wait transfer: command accepted in cycle 0, pop in cycle 1, SETUP in cycle 2, ACCESS with P_ready in cycle 3, rsp_valid in cycle 4.
  - Back-to-back throughput: 2 cycles per transfer.
- Responses are produced in command order. rsp_valid is never held for more than 1 cycle and there is no response backpressure.
- P_busy = FIFO non-empty or FSM not in IDLE or a response pending.
- A push into an empty FIFO while the FSM is busy is simply queued. Simultaneous push and pop when the FIFO is not full is allowed, and the occupancy count is unchanged.

Test Plan:
1. Write then read, zero wait: push write addr=0x05 data=0xA5, then read addr=0x05. Slave model responds with P_ready=1. Expected: write rsp_valid at cycle 4 with err=0; read rsp_rdata=0xA5. P_sel=2'b01 in both SETUP phases, and P_enable=0 in SETUP, 1 in ACCESS.
2. Slave decode: read addr=0x85 with NUM_SLAVES=2. Expected: P_sel=2'b10. With NUM_SLAVES=3, read addr=0xC0 gives rsp_err=1, rsp_timeout=0, and P_sel stays 0.
3. Wait states and timeout: slave holds P_ready low for 3 cycles. Expected: completion with err=0 and P_addr stable throughout. Then P_ready held low forever with TIMEOUT_CYCLES=16. Expected: rsp_err=1, rsp_timeout=1 after 16 ACCESS cycles, then the FSM returns to IDLE.
4. FIFO full and back-to-back: push 6 commands with the slave stalled. Expected: cmd_ready=0 after 4 queued commands plus 1 popped. After release, transfers run SETUP/ACCESS alternately with no IDLE cycle, and 6 responses arrive in order.
5. PSLVERR: read with P_ready=1 and P_slverr=1, P_rdata=0x3C. Expected: rsp_err=1, rsp_rdata=0.
6. Reset mid-ACCESS: assert P_reset for 1 cycle during a stalled transfer. Expected: the next cycle has all outputs 0 and no rsp_valid. cmd_ready=1 the following cycle, and FIFO contents are discarded.
